// File: rtl/layer_controller_cpu_debug_pkg.sv
// Shared types and jdo field positions for the OCI debug RAM arbiter.
package layer_controller_cpu_debug_pkg;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    J_WR  = 3'd1,
    J_RD  = 3'd2,
    J_RSP = 3'd3,
    A_WR  = 3'd4,
    A_RD  = 3'd5,
    A_RSP = 3'd6
  } arb_state_e;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'd0,
    CMD_WR   = 2'd1,
    CMD_RD   = 2'd2
  } jtag_cmd_e;

  function automatic logic [31:0] jdo_data(input logic [JDO_W-1:0] jdo);
    return jdo[JDO_DATA_MSB:JDO_DATA_LSB];
  endfunction

endpackage

// File: rtl/layer_controller_cpu_cpu_debug_jtag_cmd_capture.sv
// Decodes the JTAG take_action pulses into a one-deep pending command.
// LOAD is applied immediately by the top and never occupies the slot.
import layer_controller_cpu_debug_pkg::*;

module layer_controller_cpu_cpu_debug_jtag_cmd_capture #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_pulse_load,
  input  logic              i_pulse_wr,
  input  logic              i_pulse_rd,
  input  logic [JDO_W-1:0]  i_jdo,
  input  logic              i_consume,
  output logic              o_pending,
  output jtag_cmd_e         o_cmd,
  output logic [31:0]       o_data,
  output logic              o_load,
  output logic [ADDR_W-1:0] o_load_addr,
  output logic              o_overrun
);

  logic        r_pending;
  jtag_cmd_e   r_cmd;
  logic [31:0] r_data;
  logic        r_overrun;

  logic w_any_pulse;
  logic w_accept;
  logic w_new_cmd;
  logic w_unused_jdo;

  assign w_any_pulse  = i_pulse_load | i_pulse_wr | i_pulse_rd;
  // Any pulse arriving while a command is held is dropped, LOAD included.
  assign w_accept     = w_any_pulse & ~r_pending;
  assign w_new_cmd    = w_accept & ~i_pulse_load & (i_pulse_wr | i_pulse_rd);
  assign w_unused_jdo = ^{i_jdo[JDO_W-1:JDO_DATA_MSB+1], i_jdo[JDO_DATA_LSB-1:0]};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pending <= 1'b0;
      r_cmd     <= CMD_LOAD;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_any_pulse && r_pending) r_overrun <= 1'b1;
      if (w_new_cmd) begin
        r_pending <= 1'b1;
        r_cmd     <= i_pulse_wr ? CMD_WR : CMD_RD;
        r_data    <= jdo_data(i_jdo);
      end else if (i_consume) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_pending   = r_pending;
  assign o_cmd       = r_cmd;
  assign o_data      = r_data;
  assign o_load      = w_accept & i_pulse_load;
  assign o_load_addr = i_jdo[JDO_ADDR_LSB +: ADDR_W];
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/layer_controller_cpu_cpu_debug_mem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG commands and the Avalon slave.
// Build option OCIMEM_PROTECT_EN: Avalon writes to the upper (ROM) half are acked but dropped.
import layer_controller_cpu_debug_pkg::*;

module layer_controller_cpu_cpu_debug_mem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int JTAG_HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]  jdo,
  output logic [31:0]       MonDReg,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata,
  output arb_state_e        o_dbg_state,
  output logic [ADDR_W-1:0] o_dbg_jtag_addr
);

  localparam int STREAK_W = $clog2(JTAG_HOLD_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(JTAG_HOLD_MAX);

  arb_state_e          r_state;
  arb_state_e          w_next_state;
  logic [ADDR_W-1:0]   r_jtag_addr;
  logic [31:0]         r_mondreg;
  logic [31:0]         r_av_readdata;
  logic [STREAK_W-1:0] r_streak;

  logic              w_pending;
  jtag_cmd_e         w_cmd;
  logic [31:0]       w_cmd_data;
  logic              w_load;
  logic [ADDR_W-1:0] w_load_addr;
  logic              w_consume;
  logic              w_jtag_grant;
  logic              w_av_grant;
  logic              w_av_req;
  logic              w_av_ack;
  logic              w_av_wr_allowed;

  layer_controller_cpu_cpu_debug_jtag_cmd_capture #(.ADDR_W(ADDR_W)) u_capture (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_pulse_load(take_action_ocimem_a),
    .i_pulse_wr  (take_action_ocimem_b),
    .i_pulse_rd  (take_no_action_ocimem_a),
    .i_jdo       (jdo),
    .i_consume   (w_consume),
    .o_pending   (w_pending),
    .o_cmd       (w_cmd),
    .o_data      (w_cmd_data),
    .o_load      (w_load),
    .o_load_addr (w_load_addr),
    .o_overrun   (jtag_overrun)
  );

`ifdef OCIMEM_PROTECT_EN
  assign w_av_wr_allowed = ~av_address[ADDR_W-1];
`else
  assign w_av_wr_allowed = 1'b1;
`endif

  // Avalon handshake: av_read/av_write is the request and must stay stable
  // until a cycle with av_waitrequest low; that cycle completes the transfer
  // (and carries av_readdata for reads).
  assign w_av_req = av_read | av_write;

  always_comb begin
    w_next_state = r_state;
    w_consume    = 1'b0;
    w_jtag_grant = 1'b0;
    w_av_grant   = 1'b0;
    w_av_ack     = 1'b0;
    ram_addr     = '0;
    ram_wr       = 1'b0;
    ram_wdata    = '0;
    ram_be       = '0;
    case (r_state)
      IDLE: begin
        // A JTAG streak at its limit yields one grant to a waiting Avalon master.
        if (w_pending && !(w_av_req && r_streak == STREAK_MAX)) begin
          w_jtag_grant = 1'b1;
          w_consume    = 1'b1;
          w_next_state = (w_cmd == CMD_WR) ? J_WR : J_RD;
        end else if (w_av_req) begin
          w_av_grant   = 1'b1;
          w_next_state = av_write ? A_WR : A_RD;
        end
      end
      J_WR: begin
        ram_addr     = r_jtag_addr;
        ram_wr       = 1'b1;
        ram_wdata    = w_cmd_data;
        ram_be       = 4'hF;
        w_next_state = IDLE;
      end
      J_RD: begin
        ram_addr     = r_jtag_addr;
        w_next_state = J_RSP;
      end
      J_RSP: begin
        ram_addr     = r_jtag_addr;
        w_next_state = IDLE;
      end
      A_WR: begin
        ram_addr     = av_address;
        ram_wr       = w_av_wr_allowed;
        ram_wdata    = av_writedata;
        ram_be       = av_byteenable;
        w_av_ack     = 1'b1;
        w_next_state = IDLE;
      end
      A_RD: begin
        ram_addr     = av_address;
        w_next_state = A_RSP;
      end
      A_RSP: begin
        ram_addr     = av_address;
        w_av_ack     = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_jtag_addr   <= '0;
      r_mondreg     <= '0;
      r_av_readdata <= '0;
      r_streak      <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_jtag_addr <= w_load_addr;
      end else if (r_state == J_WR || r_state == J_RSP) begin
        r_jtag_addr <= r_jtag_addr + ADDR_W'(1);
      end
      if (r_state == J_WR)  r_mondreg <= w_cmd_data;
      if (r_state == J_RSP) r_mondreg <= ram_rdata;
      if (r_state == A_RSP) r_av_readdata <= ram_rdata;
      if (!w_av_req || w_av_grant) begin
        r_streak <= '0;
      end else if (w_jtag_grant && r_streak != STREAK_MAX) begin
        r_streak <= r_streak + STREAK_W'(1);
      end
    end
  end

  // Read data is forwarded straight from the RAM in the response cycle and held afterwards.
  assign av_readdata     = (r_state == A_RSP) ? ram_rdata : r_av_readdata;
  assign av_waitrequest  = w_av_req & ~w_av_ack;
  assign MonDReg         = r_mondreg;
  assign o_dbg_state     = r_state;
  assign o_dbg_jtag_addr = r_jtag_addr;

endmodule
